crc_axis_frame_arbiter: RTL and testbench

Frame-granular round-robin arbiter that lets several AXI-Stream packet sources share one CRC transmitter input. It sits between multiple packet generators and the CRC transmitter stage. A grant is held from the first beat of a frame until its `tlast` beat is accepted, so frames are never interleaved. Frame and grant status are exposed for the test harness.

---
 rtl/crc_axis_frame_arbiter.sv | 125 ++++++++++++
 tb/tb_crc_axis_frame_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_axis_frame_arbiter.sv
// Frame-granular round-robin arbiter: several AXI-Stream sources share one CRC
// transmitter input, with a grant held from first beat until the tlast handshake.
module crc_axis_frame_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 2
) (
    input  logic                          axis_aclk,
    input  logic                          axis_areset,
    input  logic                          enable,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic [NUM_SRC-1:0]            grant_onehot,
    output logic                          busy,
    output logic [DATA_WIDTH-1:0]         frame_count_out
);

    localparam int IDXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic {
        IDLE,
        XFER
    } arbState_t;

    arbState_t             r_state;
    arbState_t             w_nextState;
    logic [IDXW-1:0]       r_gntIdx;
    logic [IDXW-1:0]       r_rrPtr;
    logic [DATA_WIDTH-1:0] r_frameCount;

    logic [DATA_WIDTH-1:0] w_srcData [NUM_SRC];
    logic [IDXW-1:0]       w_selIdx;
    logic [IDXW:0]         w_cand;
    logic                  w_found;
    logic                  w_anyReq;
    logic                  w_grantStart;
    logic                  w_frameEnd;
    logic [IDXW-1:0]       w_ptrNext;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
        assign w_srcData[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Search upward from the round-robin pointer, wrapping, for the first requester.
    always_comb begin
        w_selIdx = '0;
        w_found  = 1'b0;
        w_cand   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_cand = {1'b0, r_rrPtr} + (IDXW+1)'(k);
            if (w_cand >= (IDXW+1)'(NUM_SRC)) begin
                w_cand = w_cand - (IDXW+1)'(NUM_SRC);
            end
            if (!w_found && s_axis_tvalid[w_cand[IDXW-1:0]]) begin
                w_found  = 1'b1;
                w_selIdx = w_cand[IDXW-1:0];
            end
        end
    end

    assign w_anyReq     = |s_axis_tvalid;
    assign w_grantStart = (r_state == IDLE) && enable && w_anyReq;
    assign w_frameEnd   = (r_state == XFER) && s_axis_tvalid[r_gntIdx]
                          && s_axis_tlast[r_gntIdx] && m_axis_tready;
    assign w_ptrNext    = (r_gntIdx == IDXW'(NUM_SRC - 1)) ? '0 : r_gntIdx + IDXW'(1);

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_grantStart) w_nextState = XFER;
            XFER:    if (w_frameEnd)   w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // The pointer only moves when a frame completes, so an abandoned frame leaves it untouched.
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            r_gntIdx     <= '0;
            r_rrPtr      <= '0;
            r_frameCount <= '0;
        end else begin
            if (w_grantStart) begin
                r_gntIdx <= w_selIdx;
            end
            if (w_frameEnd) begin
                r_rrPtr      <= w_ptrNext;
                r_frameCount <= r_frameCount + DATA_WIDTH'(1);
            end
        end
    end

    always_comb begin
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        grant_onehot  = '0;
        busy          = 1'b0;
        if (r_state == XFER) begin
            m_axis_tdata            = w_srcData[r_gntIdx];
            m_axis_tvalid           = s_axis_tvalid[r_gntIdx];
            m_axis_tlast            = s_axis_tlast[r_gntIdx];
            s_axis_tready[r_gntIdx] = m_axis_tready;
            grant_onehot[r_gntIdx]  = 1'b1;
            busy                    = 1'b1;
        end
    end

    assign frame_count_out = r_frameCount;

endmodule

// File: tb/tb_crc_axis_frame_arbiter.sv
// Randomised and directed bench for crc_axis_frame_arbiter, checked every cycle
// against a frame-level round-robin reference model.
module tb_crc_axis_frame_arbiter;

    localparam int DW = 8;
    localparam int NS = 3;

    logic           clk      = 1'b0;
    logic           rst      = 1'b0;
    logic           enable   = 1'b0;
    logic           mTready  = 1'b0;
    logic [NS*DW-1:0] sTdata = '0;
    logic [NS-1:0]  sTvalid  = '0;
    logic [NS-1:0]  sTlast   = '0;
    logic [NS-1:0]  sTready;
    logic [DW-1:0]  mTdata;
    logic           mTvalid;
    logic           mTlast;
    logic [NS-1:0]  grantOnehot;
    logic           busy;
    logic [DW-1:0]  frameCount;

    crc_axis_frame_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS)) dut (
        .axis_aclk       (clk),
        .axis_areset     (rst),
        .enable          (enable),
        .s_axis_tdata    (sTdata),
        .s_axis_tvalid   (sTvalid),
        .s_axis_tlast    (sTlast),
        .s_axis_tready   (sTready),
        .m_axis_tdata    (mTdata),
        .m_axis_tvalid   (mTvalid),
        .m_axis_tlast    (mTlast),
        .m_axis_tready   (mTready),
        .grant_onehot    (grantOnehot),
        .busy            (busy),
        .frame_count_out (frameCount)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: which source owns the output (-1 = none), the pointer and the frame total.
    int mGrant   = -1;
    int mPtr     = 0;
    int mCount   = 0;
    int cycleNum = 0;
    int lastEnd  = -1;
    int grantLog[$];
    int gapLog[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mGrant = -1;
            mPtr   = 0;
            mCount = 0;
        end else begin
            cycleNum++;
            if (mGrant < 0) begin
                if (enable && (sTvalid != '0)) begin
                    for (int k = 0; k < NS; k++) begin
                        if (mGrant < 0 && sTvalid[(mPtr + k) % NS]) mGrant = (mPtr + k) % NS;
                    end
                    grantLog.push_back(mGrant);
                    if (lastEnd >= 0) gapLog.push_back(cycleNum - lastEnd);
                end
            end else if (sTvalid[mGrant] && sTlast[mGrant] && mTready) begin
                mPtr    = (mGrant + 1) % NS;
                mCount  = (mCount + 1) % (1 << DW);
                mGrant  = -1;
                lastEnd = cycleNum;
            end
        end
    end

    logic [NS-1:0] hsPrev = '0;
    logic [31:0]   eData, eValid, eLast, eReady, eGrant, eBusy;

    always @(negedge clk) begin
        hsPrev = sTready & sTvalid;
        if (rst || mGrant < 0) begin
            eData = 0; eValid = 0; eLast = 0; eReady = 0; eGrant = 0; eBusy = 0;
        end else begin
            eData  = 32'(sTdata[mGrant*DW +: DW]);
            eValid = 32'(sTvalid[mGrant]);
            eLast  = 32'(sTlast[mGrant]);
            eReady = mTready ? (32'd1 << mGrant) : 32'd0;
            eGrant = 32'd1 << mGrant;
            eBusy  = 1;
        end
        checkOutput("cmpTdata",  32'(mTdata),      eData);
        checkOutput("cmpTvalid", 32'(mTvalid),     eValid);
        checkOutput("cmpTlast",  32'(mTlast),      eLast);
        checkOutput("cmpSready", 32'(sTready),     eReady);
        checkOutput("cmpGrant",  32'(grantOnehot), eGrant);
        checkOutput("cmpBusy",   32'(busy),        eBusy);
        checkOutput("cmpCount",  32'(frameCount),  32'(mCount));
    end

    // Random source driver state.
    int srcLen[NS];
    int srcBeat[NS];
    int framesLeft[NS];
    bit srcActive[NS];
    logic [NS-1:0] srcMask = '0;
    int  lenMin = 1, lenMax = 1, startPct = 100, holdPct = 0, readyPct = 100;
    bit  allowNew = 0, readyRand = 0, enableRand = 0;

    task automatic setData(input int i, input logic [DW-1:0] v);
        sTdata[i*DW +: DW] = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLogs();
        grantLog.delete();
        gapLog.delete();
        lastEnd = -1;
    endtask

    task automatic resetDriver();
        for (int i = 0; i < NS; i++) begin
            srcActive[i]  = 0;
            framesLeft[i] = 0;
            srcBeat[i]    = 0;
            srcLen[i]     = 0;
        end
        sTvalid = '0;
        sTlast  = '0;
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            step();
            if (readyRand)  mTready = ($urandom_range(99) < readyPct);
            if (enableRand) enable  = ($urandom_range(99) < 90);
            for (int i = 0; i < NS; i++) begin
                if (hsPrev[i] && srcActive[i]) begin
                    srcBeat[i]++;
                    if (srcBeat[i] == srcLen[i]) begin
                        srcActive[i] = 0;
                        sTvalid[i]   = 1'b0;
                        sTlast[i]    = 1'b0;
                    end else begin
                        setData(i, DW'($urandom));
                        sTlast[i]  = (srcBeat[i] == srcLen[i] - 1);
                        sTvalid[i] = ($urandom_range(99) >= holdPct);
                    end
                end else if (srcActive[i] && !sTvalid[i]) begin
                    sTvalid[i] = ($urandom_range(99) >= holdPct);
                end
                if (!srcActive[i] && allowNew && srcMask[i] && framesLeft[i] > 0
                    && $urandom_range(99) < startPct) begin
                    srcActive[i] = 1;
                    srcLen[i]    = $urandom_range(lenMax, lenMin);
                    srcBeat[i]   = 0;
                    framesLeft[i]--;
                    setData(i, DW'($urandom));
                    sTlast[i]    = (srcLen[i] == 1);
                    sTvalid[i]   = 1'b1;
                end
            end
        end
    endtask

    function automatic bit isQuiet();
        bit q = (mGrant < 0);
        for (int i = 0; i < NS; i++) begin
            if (srcActive[i]) q = 0;
            if (allowNew && srcMask[i] && framesLeft[i] > 0) q = 0;
        end
        return q;
    endfunction

    task automatic runUntilQuiet(input int maxCycles);
        int n = 0;
        while (!isQuiet() && n < maxCycles) begin
            applyStimulus(1);
            n++;
        end
        checkOutput("drainQuiet", 32'(isQuiet()), 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        mTready = 1'b1;
        sTvalid = 3'b111;
        repeat (3) step();
        checkOutput("rstTvalid", 32'(mTvalid), 0);
        checkOutput("rstSready", 32'(sTready), 0);
        checkOutput("rstGrant",  32'(grantOnehot), 0);
        checkOutput("rstBusy",   32'(busy), 0);
        checkOutput("rstCount",  32'(frameCount), 0);
        checkOutput("rstTdata",  32'(mTdata), 0);
        sTvalid = '0;
        rst = 1'b0;

        // Single source, four beats, ready held high.
        sTvalid = 3'b010;
        setData(1, 8'hA0);
        step();
        checkOutput("t1Grant", 32'(grantOnehot), 32'b010);
        for (int k = 0; k < 4; k++) begin
            setData(1, DW'(8'hA0 + k));
            sTlast[1] = (k == 3);
            #1;
            checkOutput("t1Beat", 32'(mTdata), 32'(8'hA0 + k));
            checkOutput("t1Valid", 32'(mTvalid), 1);
            step();
        end
        sTvalid = '0;
        sTlast  = '0;
        #1;
        checkOutput("t1Busy", 32'(busy), 0);
        checkOutput("t1Count", 32'(frameCount), 1);
        checkOutput("t1ModelPtr", 32'(mPtr), 2);
        sTvalid = 3'b111;
        sTlast  = 3'b111;
        step();
        checkOutput("t1PtrProbe", 32'(grantOnehot), 32'b100);
        step();
        sTvalid = '0;
        sTlast  = '0;

        // All three sources stream two-beat frames back to back.
        clearLogs();
        resetDriver();
        srcMask = 3'b111; lenMin = 2; lenMax = 2; startPct = 100; holdPct = 0;
        for (int i = 0; i < NS; i++) framesLeft[i] = 2;
        allowNew = 1;
        runUntilQuiet(300);
        allowNew = 0;
        checkOutput("t2NumFrames", 32'(grantLog.size()), 6);
        for (int i = 0; i < grantLog.size() && i < 6; i++) checkOutput("t2Order", 32'(grantLog[i]), 32'(i % 3));
        checkOutput("t2NumGaps", 32'(gapLog.size()), 5);
        foreach (gapLog[i]) checkOutput("t2Bubble", 32'(gapLog[i]), 1);
        checkOutput("t2Count", 32'(frameCount), 8);

        // Backpressure on a three-beat frame from source 0.
        resetDriver();
        sTvalid = 3'b001;
        setData(0, 8'h30);
        step();
        checkOutput("t3Grant", 32'(grantOnehot), 32'b001);
        begin
            int beat = 0;
            for (int c = 0; c < 5; c++) begin
                mTready = (c % 2 == 0);
                setData(0, DW'(8'h30 + beat));
                sTlast[0] = (beat == 2);
                #1;
                checkOutput("t3Ready", 32'(sTready), (c % 2 == 0) ? 32'b001 : 32'b000);
                checkOutput("t3Hold", 32'(mTdata), 32'(8'h30 + beat));
                checkOutput("t3Busy", 32'(busy), 1);
                step();
                if (c % 2 == 0) beat++;
            end
        end
        mTready = 1'b1;
        sTvalid = '0;
        sTlast  = '0;
        #1;
        checkOutput("t3Done", 32'(busy), 0);
        checkOutput("t3Count", 32'(frameCount), 9);

        // Enable dropped mid-frame: the frame finishes, then no new grants.
        sTvalid = 3'b010;
        setData(1, 8'hB0);
        step();
        checkOutput("t4Grant", 32'(grantOnehot), 32'b010);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                enable = 1'b0;
                sTvalid = 3'b111;
                sTlast[0] = 1'b1;
                sTlast[2] = 1'b1;
            end
            setData(1, DW'(8'hB0 + k));
            sTlast[1] = (k == 3);
            step();
        end
        repeat (4) begin
            #1;
            checkOutput("t4NoGrant", 32'(grantOnehot), 0);
            step();
        end
        checkOutput("t4Count", 32'(frameCount), 10);
        enable = 1'b1;
        step();
        checkOutput("t4RoundRobin", 32'(grantOnehot), 32'b100);
        step();
        sTvalid = '0;
        sTlast  = '0;
        #1;
        checkOutput("t4Count2", 32'(frameCount), 11);

        // Reset in the middle of a frame.
        sTvalid = 3'b001;
        setData(0, 8'hC0);
        step();
        for (int k = 0; k < 2; k++) begin
            setData(0, DW'(8'hC0 + k));
            step();
        end
        setData(0, 8'hC2);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t5Tvalid", 32'(mTvalid), 0);
        checkOutput("t5Tdata",  32'(mTdata), 0);
        checkOutput("t5Sready", 32'(sTready), 0);
        checkOutput("t5Grant",  32'(grantOnehot), 0);
        checkOutput("t5Busy",   32'(busy), 0);
        checkOutput("t5Count",  32'(frameCount), 0);
        step();
        sTvalid = 3'b100;
        sTlast  = 3'b100;
        setData(2, 8'hD0);
        step();
        rst = 1'b0;
        step();
        checkOutput("t5Regrant", 32'(grantOnehot), 32'b100);
        step();
        sTvalid = '0;
        sTlast  = '0;
        #1;
        checkOutput("t5CountAfter", 32'(frameCount), 1);

        // Alternating single-beat frames from sources 0 and 1.
        for (int f = 0; f < 4; f++) begin
            sTvalid = NS'(1 << (f % 2));
            sTlast  = NS'(1 << (f % 2));
            setData(f % 2, DW'(8'hE0 + f));
            step();
            checkOutput("t6Grant", 32'(grantOnehot), 32'(1 << (f % 2)));
            checkOutput("t6Busy", 32'(busy), 1);
            step();
            sTvalid = '0;
            sTlast  = '0;
            #1;
            checkOutput("t6OneCycle", 32'(busy), 0);
            checkOutput("t6Count", 32'(frameCount), 32'(2 + f));
        end

        // Randomised traffic with stalls, source bubbles and enable toggling.
        clearLogs();
        resetDriver();
        srcMask = 3'b111; lenMin = 1; lenMax = 5; startPct = 40; holdPct = 20;
        readyPct = 70; readyRand = 1; enableRand = 1;
        for (int i = 0; i < NS; i++) framesLeft[i] = 1000;
        allowNew = 1;
        applyStimulus(3000);
        allowNew = 0; readyRand = 0; enableRand = 0; holdPct = 0;
        mTready = 1'b1;
        enable  = 1'b1;
        runUntilQuiet(500);
        checkOutput("rndActivity", 32'(grantLog.size() > 20), 1);

        // Frame counter wraps from all-ones to zero.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        checkOutput("wrapStart", 32'(frameCount), 0);
        resetDriver();
        srcMask = 3'b001; lenMin = 1; lenMax = 1; startPct = 100;
        framesLeft[0] = 255;
        allowNew = 1;
        runUntilQuiet(2000);
        checkOutput("wrapFull", 32'(frameCount), 32'hFF);
        framesLeft[0] = 1;
        runUntilQuiet(50);
        checkOutput("wrapZero", 32'(frameCount), 0);
        allowNew = 0;

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
